data_mem_responder: RTL
=======================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024: number of 32-bit storage words; must be a power of two.
REQ-002 Parameter LATENCY, default 2: wait cycles between request acceptance and response; range 0..15.
REQ-003 Port Clk  input  1: single clock; all state changes on the rising edge.
REQ-004 Port Reset  input  1: asynchronous, active-high reset.
REQ-005 Port req_valid  input  1: a request is presented.
REQ-006 Port req_ready  output  1: the responder can accept a request this cycle.
REQ-007 Port req_write  input  1: 1 = store, 0 = load.
REQ-008 Port req_size  input  2: 00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-009 Port req_signed  input  1: sign-extend byte and half loads.
REQ-010 Port req_addr  input  32: byte address.
REQ-011 Port req_wdata  input  32: store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-012 Port resp_valid  output  1: one-cycle pulse that completes a request.
REQ-013 Port resp_rdata  output  32: load data, extended to 32 bits; 0 for stores and errors.
REQ-014 Port resp_err  output  1: valid with resp_valid; flags a misaligned or illegal-size request.

Function
REQ-015 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-016 req_ready SHALL be 1 only in IDLE.
REQ-017 A request SHALL be accepted when req_valid and req_ready are both 1 on the same edge. At acceptance, write, size, signed, address and wdata SHALL be captured.
REQ-018 On acceptance with LATENCY > 0, the FSM SHALL move IDLE -> WAIT and load a down-counter with LATENCY-1. WAIT -> RESP when the counter is 0; otherwise the counter decrements.
REQ-019 With LATENCY = 0, the FSM SHALL move IDLE -> RESP directly.
REQ-020 RESP SHALL last exactly one cycle with resp_valid = 1, then return to IDLE.
REQ-021 Total latency SHALL be LATENCY+1 cycles from the accepting edge to the resp_valid cycle. Back-to-back requests SHALL be separated by at least one IDLE cycle.
REQ-022 Word index SHALL be addr[log2(DEPTH_WORDS)+1:2]. Higher address bits are ignored, so addresses wrap modulo the memory size.
REQ-023 Byte lanes are little-endian: addr[1:0] = 0 selects bits [7:0].
REQ-024 Misalignment rules:
  - half with addr[0] = 1 is misaligned;
  - word with addr[1:0] != 0 is misaligned;
  - size 11 is illegal.
  Any of these SHALL give resp_err = 1, resp_rdata = 0 and no memory write.
REQ-025 A store SHALL update only the addressed byte lanes. The write SHALL commit on the WAIT->RESP (or IDLE->RESP) edge, never earlier.
REQ-026 A load SHALL read the word on entry to RESP, select the lanes and extend them: zero-extend when req_signed = 0, sign-extend from bit 7 or bit 15 when req_signed = 1.
REQ-027 resp_rdata and resp_err SHALL be 0 whenever resp_valid = 0.
REQ-028 req_valid asserted outside IDLE SHALL be ignored; no queueing.

Reset
REQ-029 Reset SHALL force the FSM to IDLE, the counter to 0, resp_valid = 0, resp_rdata = 0 and resp_err = 0. Consequently req_ready = 1 immediately after reset.
REQ-030 Reset in WAIT SHALL abort the request. A store in flight SHALL NOT commit.
REQ-031 Memory contents SHALL NOT be cleared by reset.

Structure
REQ-032 Size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and FSM state encodings SHALL live in a shared package, mem_pkg.
REQ-033 Lane select, store byte-enable generation and load extension SHALL be one combinational sub-module, mem_lane_align. The FSM and storage array SHALL stay in data_mem_responder.

Verification
REQ-034 Word store followed by word load, LATENCY = 2:
  - store 0xDEADBEEF to 0x10, then load 0x10;
  - resp_valid SHALL rise 3 cycles after each accept;
  - load returns 0xDEADBEEF.
REQ-035 Signed and unsigned byte loads:
  - store word 0x80FF7F01 at 0x20;
  - lb 0x23 returns 0xFFFFFF80;
  - lbu 0x21 returns 0x0000007F;
  - lh 0x22 returns 0xFFFF80FF.
REQ-036 Misaligned half store:
  - word 0x11223344 already stored at 0x30;
  - sh 0xAAAA to 0x31 returns resp_err = 1;
  - a following word load of 0x30 returns 0x11223344.
REQ-037 Reset during WAIT:
  - assert Reset in the WAIT cycle of a store of 0x55 to 0x40;
  - req_ready SHALL be 1 immediately and resp_valid SHALL never pulse;
  - a later load of 0x40 returns the old value.
REQ-038 Wrap and handshake, DEPTH_WORDS = 1024:
  - store at 0x1004, then load at 0x0004 returns the same data;
  - req_valid held high through WAIT SHALL be accepted exactly once per IDLE visit.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings for the data memory responder: access sizes, FSM states
// and the alignment rule used by both the lane logic and the controller.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane steering: store byte enables and data placement, plus
// load lane extraction with zero/sign extension. Errors suppress both paths.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        is_signed,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] word_data,
    output logic        err,
    output logic [3:0]  byte_en,
    output logic [31:0] lane_wdata,
    output logic [31:0] load_data
);

    logic [31:0] shifted;

    always_comb begin
        err        = is_misaligned(size, addr_lo);
        byte_en    = 4'b0000;
        lane_wdata = store_data << {addr_lo, 3'b000};
        shifted    = word_data >> {addr_lo, 3'b000};
        load_data  = 32'd0;
        if (!err) begin
            case (size)
                SZ_BYTE: begin
                    byte_en   = 4'b0001 << addr_lo;
                    load_data = {{24{is_signed & shifted[7]}}, shifted[7:0]};
                end
                SZ_HALF: begin
                    byte_en   = 4'b0011 << addr_lo;
                    load_data = {{16{is_signed & shifted[15]}}, shifted[15:0]};
                end
                SZ_WORD: begin
                    byte_en   = 4'b1111;
                    load_data = shifted;
                end
                default: begin
                    byte_en   = 4'b0000;
                    load_data = 32'd0;
                end
            endcase
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Single-request data memory with fixed response latency. Stores commit and
// loads read on the edge that enters RESP, so an aborted request leaves no trace.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;

    state_t            state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              write_reg;
    logic [1:0]        size_reg;
    logic              signed_reg;
    logic [31:0]       addr_reg;
    logic [31:0]       wdata_reg;
    logic              resp_valid_reg;
    logic              resp_err_reg;

    logic              in_idle;
    logic              accept;
    logic              to_resp;
    logic              commit;
    logic              op_write;
    logic [1:0]        op_size;
    logic              op_signed;
    logic [31:0]       op_addr;
    logic [31:0]       op_wdata;
    logic [AW-1:0]     word_idx;
    logic              unused_addr_bits;

    logic              err;
    logic [3:0]        byte_en;
    logic [31:0]       lane_wdata;
    logic [31:0]       load_data;
    logic [31:0]       rd_word;

    assign in_idle = (state_reg == ST_IDLE);
    assign accept  = req_valid && in_idle;
    assign to_resp = ((state_reg == ST_WAIT) && (cnt_reg == '0)) || (accept && (LATENCY == 0));

    // In IDLE the live request drives the datapath (zero-latency case);
    // afterwards the captured copy does.
    assign op_write  = in_idle ? req_write  : write_reg;
    assign op_size   = in_idle ? req_size   : size_reg;
    assign op_signed = in_idle ? req_signed : signed_reg;
    assign op_addr   = in_idle ? req_addr   : addr_reg;
    assign op_wdata  = in_idle ? req_wdata  : wdata_reg;

    assign word_idx         = op_addr[AW+1:2];
    assign unused_addr_bits = ^op_addr[31:AW+2];
    assign commit           = to_resp && op_write && !Reset;

    mem_lane_align u_align (
        .size       (op_size),
        .is_signed  (op_signed),
        .addr_lo    (op_addr[1:0]),
        .store_data (op_wdata),
        .word_data  (rd_word),
        .err        (err),
        .byte_en    (byte_en),
        .lane_wdata (lane_wdata),
        .load_data  (load_data)
    );

    // One byte-wide RAM per lane so each byte enable maps to its own write port.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] mem_lane [DEPTH_WORDS];
        logic [7:0] rd_byte_reg;

        always_ff @(posedge Clk) begin
            if (commit && byte_en[gi]) begin
                mem_lane[word_idx] <= lane_wdata[gi*8 +: 8];
            end
            if (to_resp) begin
                rd_byte_reg <= mem_lane[word_idx];
            end
        end

        assign rd_word[gi*8 +: 8] = rd_byte_reg;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            write_reg      <= 1'b0;
            size_reg       <= SZ_BYTE;
            signed_reg     <= 1'b0;
            addr_reg       <= 32'd0;
            wdata_reg      <= 32'd0;
            resp_valid_reg <= 1'b0;
            resp_err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (req_valid) begin
                        write_reg  <= req_write;
                        size_reg   <= req_size;
                        signed_reg <= req_signed;
                        addr_reg   <= req_addr;
                        wdata_reg  <= req_wdata;
                        if (LATENCY == 0) begin
                            state_reg      <= ST_RESP;
                            resp_valid_reg <= 1'b1;
                            resp_err_reg   <= err;
                        end else begin
                            state_reg <= ST_WAIT;
                            cnt_reg   <= CNT_LOAD;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt_reg == '0) begin
                        state_reg      <= ST_RESP;
                        resp_valid_reg <= 1'b1;
                        resp_err_reg   <= err;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                ST_RESP: begin
                    state_reg      <= ST_IDLE;
                    resp_valid_reg <= 1'b0;
                    resp_err_reg   <= 1'b0;
                end
                default: begin
                    state_reg      <= ST_IDLE;
                    resp_valid_reg <= 1'b0;
                    resp_err_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = in_idle;
    assign resp_valid = resp_valid_reg;
    assign resp_err   = resp_err_reg;
    assign resp_rdata = (resp_valid_reg && !write_reg) ? load_data : 32'd0;

endmodule
